// File: rtl/fsm_pkg.sv
// Shared types for the fsm state-trace observer: state encoding, trace record
// layout and the tracker's arm state.
package fsm_pkg;
  localparam int STATE_W    = 3;
  localparam int NUM_STATES = 5;
  localparam int DWELL_W    = 8;

  typedef logic [STATE_W-1:0] state_t;

  typedef struct packed {
    state_t             state;
    logic [DWELL_W-1:0] dwell;
  } trace_rec_t;

  typedef enum logic {
    TRK_IDLE  = 1'b0,
    TRK_ARMED = 1'b1
  } trk_state_t;

  function automatic logic is_illegal(input state_t s);
    return s >= state_t'(NUM_STATES);
  endfunction
endpackage

// File: rtl/fsm_trace_if.sv
// Record output port of the trace observer.
// Handshake: a record transfers on a posedge where out_valid && out_ready;
// out_state/out_dwell hold steady while out_valid && !out_ready.
interface fsm_trace_if;
  import fsm_pkg::*;

  logic               out_valid;
  logic               out_ready;
  state_t             out_state;
  logic [DWELL_W-1:0] out_dwell;

  modport master (output out_valid, out_state, out_dwell, input out_ready);
  modport slave  (input out_valid, out_state, out_dwell, output out_ready);
endinterface

// File: rtl/fsm_trace_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO with no
// simultaneous pop is dropped and flagged for one cycle on drop.
module fsm_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         pop_ok;
  logic         push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fsm_trace.sv
// Observer for the 5-state fsm: measures dwell per state, queues a record on
// every state change, and keeps sticky illegal/overflow flags plus a transition count.
module fsm_trace
  import fsm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  state_t             y,
  fsm_trace_if.master        trace,
  output logic [15:0]        trans_count,
  output logic               illegal,
  output state_t             illegal_state,
  output logic               overflow,
  output trk_state_t         dbg_state
);
  trk_state_t         trk_q, trk_d;
  state_t             prev_y;
  logic [DWELL_W-1:0] dwell;
  logic               change;
  logic               drop;
  logic               full;
  logic               empty;
  trace_rec_t         rec_in, rec_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) trk_q <= TRK_IDLE;
    else       trk_q <= trk_d;
  end

  always_comb begin
    trk_d = trk_q;
    if (en && trk_q == TRK_IDLE) trk_d = TRK_ARMED;
  end

  assign dbg_state    = trk_q;
  assign change       = en && (trk_q == TRK_ARMED) && (y != prev_y);
  assign rec_in.state = prev_y;
  assign rec_in.dwell = dwell;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_y        <= '0;
      dwell         <= '0;
      trans_count   <= '0;
      illegal       <= 1'b0;
      illegal_state <= '0;
      overflow      <= 1'b0;
    end else begin
      if (en) begin
        if (trk_q == TRK_IDLE || change) begin
          prev_y <= y;
          dwell  <= DWELL_W'(1);
        end else if (dwell != '1) begin
          dwell <= dwell + 1'b1;
        end
        if (change) trans_count <= trans_count + 16'd1;
        // Only the first illegal value is kept; later ones are just traced.
        if (is_illegal(y) && !illegal) begin
          illegal       <= 1'b1;
          illegal_state <= y;
        end
      end
      if (drop) overflow <= 1'b1;
    end
  end

  fsm_trace_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(trace_rec_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (change),
    .din   (rec_in),
    .pop   (trace.out_ready),
    .dout  (rec_out),
    .full  (full),
    .empty (empty),
    .drop  (drop)
  );

  assign trace.out_valid = !empty;
  assign trace.out_state = rec_out.state;
  assign trace.out_dwell = rec_out.dwell;

  // Full is implied by drop; kept visible for debug probing.
  logic unused_full;
  assign unused_full = full;
endmodule

// File: doc/fsm_trace.md
Name: fsm_trace

Overview:
Downstream observer for the 5-state fsm. Samples the fsm state output y every enabled cycle and measures how long each state is held. On each state change it pushes a {state, dwell} record into a small FIFO, drained through a valid/ready port. Also keeps sticky illegal-state and overflow flags and a transition counter, for on-board checking of the fsm without a simulator.

Parameters:
NUM_STATES, 5, number of legal states; y values >= NUM_STATES are illegal
STATE_W, 3, width of y
DWELL_W, 8, dwell counter width; saturates at 2^DWELL_W-1
DEPTH, 8, FIFO entries; must be a power of 2, >= 2

Ports:
clock  in  1  single clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
en  in  1  sample enable; must be the same en that drives the fsm
y  in  STATE_W  fsm state output
out_valid  out  1  FIFO head holds a record
out_ready  in  1  consumer accepts the head this cycle
out_state  out  STATE_W  state that was left
out_dwell  out  DWELL_W  cycles spent in out_state (saturated)
trans_count  out  16  number of transitions detected; wraps at 2^16
illegal  out  1  sticky: an illegal y was sampled
illegal_state  out  STATE_W  first illegal y value seen
overflow  out  1  sticky: a record was dropped because the FIFO was full

Behaviour:
- Reset (async assert, released synchronously by the environment): all outputs 0; FIFO empty; armed=0; prev_y=0; dwell=0.
- en=0 cycle: no state changes at all (dwell, prev_y, armed and flags hold). FIFO pops still occur.
- First en=1 cycle after reset (armed=0): prev_y<=y, dwell<=1, armed<=1. No push.
- en=1, armed=1, y==prev_y: dwell<=dwell+1, saturating at all-ones.
- en=1, armed=1, y!=prev_y: push {prev_y, dwell}; prev_y<=y; dwell<=1; trans_count<=trans_count+1 (wrapping). trans_count increments even when the push is dropped.
- Illegal check on every en=1 cycle: if y>=NUM_STATES and illegal=0, set illegal<=1 and illegal_state<=y. Later illegal values do not overwrite illegal_state. Illegal values are otherwise tracked like legal states.
- Latency: for a change sampled at posedge k, the record is written at posedge k. If the FIFO was empty, out_valid=1 after posedge k.
- Pop: occurs on a posedge where out_valid && out_ready. out_state and out_dwell are stable while out_valid && !out_ready.
- FIFO full and push with no pop: record dropped, overflow<=1; existing entries untouched.
- FIFO full with push and pop in the same cycle: both occur; no drop; occupancy stays DEPTH.
- FIFO empty with push and out_ready=1: no bypass. The record appears the next cycle.
- Pointers are log2(DEPTH)+1 bits, wrapping naturally. full = MSBs differ and low bits equal. empty = pointers equal.
- Reset mid-operation: out_valid drops asynchronously; FIFO contents are discarded; re-arms on the next en=1 cycle.
- Sticky flags clear only on reset.

Decomposition:
- Shared package fsm_pkg: STATE_W, NUM_STATES, typedef state_t, typedef trace_rec_t {state_t state; logic [DWELL_W-1:0] dwell}.
- One sub-module fsm_trace_fifo: synchronous FIFO with push/pop, full/empty and drop flag, parameterised by DEPTH and record width, async active-high reset.
- Top level holds the dwell/transition tracker and the flags.

Test Plan:
- Reset held 16 cycles, en=1, out_ready=1, y=0,0,0,1,1,2 -> records (0,3) then (1,2); trans_count=2; illegal=0; overflow=0.
- y=3 held 300 cycles then y=4 -> one record (3,255); no wrap of dwell.
- out_ready=0, DEPTH=8, y toggles 0/1 every cycle for 10 transitions -> 8 entries held, overflow=1, trans_count=10; draining yields (0,1),(1,1),... with the first record preserved.
- Full FIFO, transition with out_ready=1 in the same cycle -> no drop; overflow stays 0; occupancy stays 8.
- y=2,2, then en=0 for 5 cycles with y=2, then en=1, y=2, then y=6 -> record (2,3); illegal=1; illegal_state=6. A later y=7 leaves illegal_state=6.
- Reset asserted mid-stream between clock edges -> out_valid, trans_count and flags go 0 before the next posedge. The first en cycle after release re-arms with no record.
